// File: rtl/mipi_rx_packet_decoder.sv
// mipi_rx_packet_decoder
//   Decodes MIPI CSI-2 style packet headers and payload words into a pixel
//   FIFO write stream plus frame/line timing pulses and sticky error flags.
//
// Ports
//   clk_periph    in   system clock, rising edge
//   rstn          in   asynchronous active-low reset
//   rx_hdr_valid  in   one-cycle packet header strobe
//   rx_hdr_dt     in   [5:0]  header data type
//   rx_hdr_wc     in   [15:0] long: payload byte count; short: data field
//   rx_pld_valid  in   payload word strobe
//   rx_pld_data   in   [31:0] payload word
//   rx_pld_last   in   final payload word of the packet
//   fifo_full     in   downstream pixel FIFO full
//   fifo_wr_en    out  pixel FIFO write strobe (one cycle)
//   fifo_wr_data  out  [31:0] pixel FIFO write data
//   vsync         out  one-cycle frame-start pulse
//   hsync         out  one-cycle line-start pulse
//   frame_active  out  high between accepted FS and FE
//   line_count    out  [15:0] completed pixel packets in current frame
//   frame_count   out  [15:0] completed frames (wrapping)
//   err_wc        out  sticky word-count error
//   err_ovf       out  sticky FIFO overflow error
//   err_proto     out  sticky protocol error
module mipi_rx_packet_decoder #(
    parameter logic [5:0] PIXEL_DT = 6'h24
) (
    input  logic        clk_periph,
    input  logic        rstn,
    input  logic        rx_hdr_valid,
    input  logic [5:0]  rx_hdr_dt,
    input  logic [15:0] rx_hdr_wc,
    input  logic        rx_pld_valid,
    input  logic [31:0] rx_pld_data,
    input  logic        rx_pld_last,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_data,
    output logic        vsync,
    output logic        hsync,
    output logic        frame_active,
    output logic [15:0] line_count,
    output logic [15:0] frame_count,
    output logic        err_wc,
    output logic        err_ovf,
    output logic        err_proto
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FRAME   = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;
    localparam logic [1:0] DISCARD = 2'd3;

    localparam logic [5:0] DT_FS = 6'h00;
    localparam logic [5:0] DT_FE = 6'h01;
    localparam logic [5:0] DT_LS = 6'h02;

    logic [1:0]  state;
    logic        disc_ret;      // DISCARD returns to FRAME (1) or IDLE (0)
    logic [16:0] exp_words;
    logic [16:0] word_cnt;

    logic        aborting;
    logic        base_in_frame;
    logic [1:0]  base_state;
    logic        hdr_long;
    logic [16:0] wc_words;
    logic [16:0] cnt_inc;

    // A header seen mid-packet first aborts the packet; the header is then
    // decoded against the state the packet was entered from ("base").
    always_comb begin
        aborting      = rx_hdr_valid && (state == PAYLOAD || state == DISCARD);
        base_in_frame = (state == FRAME) || (state == PAYLOAD) ||
                        (state == DISCARD && disc_ret);
        base_state    = base_in_frame ? FRAME : IDLE;
        hdr_long      = (rx_hdr_dt >= 6'h10);
        wc_words      = ({1'b0, rx_hdr_wc} + 17'd3) >> 2;
        cnt_inc       = word_cnt + 17'd1;
    end

    always_ff @(posedge clk_periph or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            disc_ret     <= 1'b0;
            exp_words    <= '0;
            word_cnt     <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            vsync        <= 1'b0;
            hsync        <= 1'b0;
            frame_active <= 1'b0;
            line_count   <= '0;
            frame_count  <= '0;
            err_wc       <= 1'b0;
            err_ovf      <= 1'b0;
            err_proto    <= 1'b0;
        end else begin
            fifo_wr_en <= 1'b0;
            vsync      <= 1'b0;
            hsync      <= 1'b0;

            if (rx_hdr_valid) begin
                if (aborting) err_proto <= 1'b1;
                case (rx_hdr_dt)
                    DT_FS: begin
                        // Flag clear happens before the re-entry error.
                        state        <= FRAME;
                        frame_active <= 1'b1;
                        line_count   <= '0;
                        err_wc       <= 1'b0;
                        err_ovf      <= 1'b0;
                        err_proto    <= base_in_frame;
                        vsync        <= 1'b1;
                    end
                    DT_FE: begin
                        state <= IDLE;
                        if (base_in_frame) begin
                            frame_active <= 1'b0;
                            frame_count  <= frame_count + 16'd1;
                        end else begin
                            err_proto <= 1'b1;
                        end
                    end
                    DT_LS: begin
                        state <= base_state;
                        if (base_in_frame) hsync <= 1'b1;
                        else               err_proto <= 1'b1;
                    end
                    default: begin
                        if (!hdr_long || rx_hdr_wc == 16'd0) begin
                            state <= base_state;
                        end else if (base_in_frame && rx_hdr_dt == PIXEL_DT) begin
                            state     <= PAYLOAD;
                            exp_words <= wc_words;
                            word_cnt  <= '0;
                        end else begin
                            state    <= DISCARD;
                            disc_ret <= base_in_frame;
                            if (!base_in_frame) err_proto <= 1'b1;
                        end
                    end
                endcase
            end else if (rx_pld_valid) begin
                case (state)
                    PAYLOAD: begin
                        word_cnt <= cnt_inc;
                        if (word_cnt < exp_words) begin
                            if (fifo_full) begin
                                err_ovf <= 1'b1;
                            end else begin
                                fifo_wr_en   <= 1'b1;
                                fifo_wr_data <= rx_pld_data;
                            end
                        end else begin
                            err_wc <= 1'b1;
                        end
                        if (rx_pld_last) begin
                            if (cnt_inc != exp_words) err_wc <= 1'b1;
                            line_count <= line_count + 16'd1;
                            state      <= FRAME;
                        end
                    end
                    DISCARD: begin
                        if (rx_pld_last) state <= disc_ret ? FRAME : IDLE;
                    end
                    default: err_proto <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mipi_rx_packet_decoder.sv
// tb_mipi_rx_packet_decoder
//   Directed-vector bench for mipi_rx_packet_decoder. Inputs change on the
//   falling clock edge; registered outputs are sampled on the following
//   falling edge, i.e. one rising edge after the stimulus.
module tb_mipi_rx_packet_decoder;

    logic        clk_periph = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_hdr_valid = 1'b0;
    logic [5:0]  rx_hdr_dt = '0;
    logic [15:0] rx_hdr_wc = '0;
    logic        rx_pld_valid = 1'b0;
    logic [31:0] rx_pld_data = '0;
    logic        rx_pld_last = 1'b0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        vsync;
    logic        hsync;
    logic        frame_active;
    logic [15:0] line_count;
    logic [15:0] frame_count;
    logic        err_wc;
    logic        err_ovf;
    logic        err_proto;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int vs_cnt = 0;
    int hs_cnt = 0;
    logic [15:0] fc_exp = '0;

    mipi_rx_packet_decoder #(.PIXEL_DT(6'h24)) dut (
        .clk_periph  (clk_periph),
        .rstn        (rstn),
        .rx_hdr_valid(rx_hdr_valid),
        .rx_hdr_dt   (rx_hdr_dt),
        .rx_hdr_wc   (rx_hdr_wc),
        .rx_pld_valid(rx_pld_valid),
        .rx_pld_data (rx_pld_data),
        .rx_pld_last (rx_pld_last),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .vsync       (vsync),
        .hsync       (hsync),
        .frame_active(frame_active),
        .line_count  (line_count),
        .frame_count (frame_count),
        .err_wc      (err_wc),
        .err_ovf     (err_ovf),
        .err_proto   (err_proto)
    );

    always #5 clk_periph = ~clk_periph;

    // Pulse counters; read them only after a #1 settle past the falling edge.
    always @(negedge clk_periph) begin
        if (fifo_wr_en) wr_cnt++;
        if (vsync)      vs_cnt++;
        if (hsync)      hs_cnt++;
    end

    task automatic send_hdr(input logic [5:0] dt, input logic [15:0] wc);
        rx_hdr_valid = 1'b1; rx_hdr_dt = dt; rx_hdr_wc = wc;
        @(negedge clk_periph);
        rx_hdr_valid = 1'b0; rx_hdr_dt = '0; rx_hdr_wc = '0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic full);
        rx_pld_valid = 1'b1; rx_pld_data = d; rx_pld_last = last; fifo_full = full;
        @(negedge clk_periph);
        rx_pld_valid = 1'b0; rx_pld_data = '0; rx_pld_last = 1'b0; fifo_full = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk_periph);
        @(negedge clk_periph);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #1;
        vectors++;
        if ({fifo_wr_en, vsync, hsync, frame_active, err_wc, err_ovf, err_proto} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b exp 0000000",
                     {fifo_wr_en, vsync, hsync, frame_active, err_wc, err_ovf, err_proto});
        end
        vectors++;
        if ({line_count, frame_count, fifo_wr_data} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_counts got %h exp 0", {line_count, frame_count, fifo_wr_data});
        end
        @(negedge clk_periph);
        rstn = 1'b1;
        @(negedge clk_periph);
    endtask

    task automatic test_basic_frame();
        int w0, v0, h0;
        logic [31:0] words [3];
        words[0] = 32'h1122_3344; words[1] = 32'hA5A5_0F0F; words[2] = 32'hDEAD_BEEF;
        #1; w0 = wr_cnt; v0 = vs_cnt; h0 = hs_cnt;
        @(negedge clk_periph);
        send_hdr(6'h00, 16'h0);
        vectors++;
        if ({vsync, frame_active} !== 2'b11) begin
            miscompares++;
            $display("FAIL fs_vsync got %b exp 11", {vsync, frame_active});
        end
        send_hdr(6'h02, 16'h0);
        vectors++;
        if ({vsync, hsync} !== 2'b01) begin
            miscompares++;
            $display("FAIL ls_hsync got %b exp 01", {vsync, hsync});
        end
        send_hdr(6'h24, 16'd12);
        for (int i = 0; i < 3; i++) begin
            send_word(words[i], i == 2, 1'b0);
            vectors++;
            if (fifo_wr_en !== 1'b1 || fifo_wr_data !== words[i]) begin
                miscompares++;
                $display("FAIL pix_write%0d got en=%b data=%h exp en=1 data=%h",
                         i, fifo_wr_en, fifo_wr_data, words[i]);
            end
        end
        vectors++;
        if (line_count !== 16'd1) begin
            miscompares++;
            $display("FAIL basic_line_count got %0d exp 1", line_count);
        end
        send_hdr(6'h03, 16'h0);
        send_hdr(6'h01, 16'h0);
        fc_exp = fc_exp + 16'd1;
        vectors++;
        if ({frame_active, frame_count} !== {1'b0, fc_exp}) begin
            miscompares++;
            $display("FAIL basic_fe got active=%b fc=%0d exp active=0 fc=%0d",
                     frame_active, frame_count, fc_exp);
        end
        settle();
        vectors++;
        if (wr_cnt - w0 !== 3 || vs_cnt - v0 !== 1 || hs_cnt - h0 !== 1) begin
            miscompares++;
            $display("FAIL basic_pulses got wr=%0d vs=%0d hs=%0d exp 3 1 1",
                     wr_cnt - w0, vs_cnt - v0, hs_cnt - h0);
        end
        vectors++;
        if ({err_wc, err_ovf, err_proto} !== 3'b000) begin
            miscompares++;
            $display("FAIL basic_errs got %b exp 000", {err_wc, err_ovf, err_proto});
        end
    endtask

    task automatic test_wc_error();
        int w0;
        send_hdr(6'h00, 16'h0);
        send_hdr(6'h24, 16'd10);   // expects 3 words
        send_word(32'h0000_0001, 1'b0, 1'b0);
        send_word(32'h0000_0002, 1'b1, 1'b0);
        vectors++;
        if ({err_wc, err_ovf, err_proto, line_count} !== {3'b100, 16'd1}) begin
            miscompares++;
            $display("FAIL wc_short got errs=%b lc=%0d exp errs=100 lc=1",
                     {err_wc, err_ovf, err_proto}, line_count);
        end
        // FS while already in a frame: flags clear, then protocol error.
        send_hdr(6'h00, 16'h0);
        vectors++;
        if ({err_wc, err_proto, line_count} !== {2'b01, 16'd0}) begin
            miscompares++;
            $display("FAIL fs_in_frame got wc=%b proto=%b lc=%0d exp 0 1 0",
                     err_wc, err_proto, line_count);
        end
        settle(); w0 = wr_cnt;
        send_hdr(6'h24, 16'd8);    // expects 2 words
        send_word(32'hC0DE_0001, 1'b0, 1'b0);
        send_word(32'hC0DE_0002, 1'b0, 1'b0);
        vectors++;
        if (err_wc !== 1'b0) begin
            miscompares++;
            $display("FAIL wc_exact_so_far got err_wc=%b exp 0", err_wc);
        end
        send_word(32'hC0DE_0003, 1'b1, 1'b0);
        vectors++;
        if ({fifo_wr_en, err_wc} !== 2'b01) begin
            miscompares++;
            $display("FAIL wc_extra got en=%b err_wc=%b exp 0 1", fifo_wr_en, err_wc);
        end
        settle();
        vectors++;
        if (wr_cnt - w0 !== 2) begin
            miscompares++;
            $display("FAIL wc_extra_writes got %0d exp 2", wr_cnt - w0);
        end
    endtask

    task automatic test_overflow();
        int w0;
        send_hdr(6'h01, 16'h0);
        fc_exp = fc_exp + 16'd1;
        send_hdr(6'h00, 16'h0);
        settle(); w0 = wr_cnt;
        send_hdr(6'h24, 16'd8);
        send_word(32'h5555_AAAA, 1'b0, 1'b0);
        send_word(32'h6666_BBBB, 1'b1, 1'b1);
        vectors++;
        if ({fifo_wr_en, err_ovf, err_wc, err_proto} !== 4'b0100) begin
            miscompares++;
            $display("FAIL ovf_flags got %b exp 0100", {fifo_wr_en, err_ovf, err_wc, err_proto});
        end
        settle();
        vectors++;
        if (wr_cnt - w0 !== 1) begin
            miscompares++;
            $display("FAIL ovf_writes got %0d exp 1", wr_cnt - w0);
        end
        send_hdr(6'h00, 16'h0);
        vectors++;
        if (err_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear got %b exp 0", err_ovf);
        end
    endtask

    task automatic test_discard();
        int w0;
        send_hdr(6'h01, 16'h0);
        fc_exp = fc_exp + 16'd1;
        send_hdr(6'h00, 16'h0);
        settle(); w0 = wr_cnt;
        send_hdr(6'h2A, 16'd8);
        send_word(32'h1234_5678, 1'b0, 1'b0);
        send_word(32'h9ABC_DEF0, 1'b1, 1'b0);
        send_hdr(6'h24, 16'd0);    // zero-length pixel packet: no state change
        send_hdr(6'h02, 16'h0);    // hsync only if back in FRAME
        vectors++;
        if ({hsync, err_wc, err_ovf, err_proto, line_count} !== {4'b1000, 16'd0}) begin
            miscompares++;
            $display("FAIL discard_frame got hs=%b errs=%b lc=%0d exp hs=1 errs=000 lc=0",
                     hsync, {err_wc, err_ovf, err_proto}, line_count);
        end
        send_hdr(6'h01, 16'h0);
        fc_exp = fc_exp + 16'd1;
        send_hdr(6'h24, 16'd8);    // long pixel header outside a frame
        send_word(32'hFFFF_0000, 1'b0, 1'b0);
        send_word(32'hFFFF_0001, 1'b1, 1'b0);
        vectors++;
        if ({err_proto, frame_active} !== 2'b10) begin
            miscompares++;
            $display("FAIL idle_long got proto=%b active=%b exp 1 0", err_proto, frame_active);
        end
        settle();
        vectors++;
        if (wr_cnt - w0 !== 0) begin
            miscompares++;
            $display("FAIL discard_writes got %0d exp 0", wr_cnt - w0);
        end
    endtask

    task automatic test_abort();
        send_hdr(6'h00, 16'h0);
        send_hdr(6'h24, 16'd12);
        send_word(32'hAB00_0001, 1'b0, 1'b0);
        vectors++;
        if (err_proto !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_pre got proto=%b exp 0", err_proto);
        end
        send_hdr(6'h01, 16'h0);
        fc_exp = fc_exp + 16'd1;
        vectors++;
        if ({err_proto, frame_active, line_count, frame_count} !== {2'b10, 16'd0, fc_exp}) begin
            miscompares++;
            $display("FAIL abort_fe got proto=%b active=%b lc=%0d fc=%0d exp 1 0 0 %0d",
                     err_proto, frame_active, line_count, frame_count, fc_exp);
        end
    endtask

    task automatic test_reset_mid_packet();
        int w0;
        send_hdr(6'h00, 16'h0);
        send_hdr(6'h24, 16'd8);
        send_word(32'h7777_0001, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        vectors++;
        if ({fifo_wr_en, frame_active, frame_count, fifo_wr_data} !== 50'h0) begin
            miscompares++;
            $display("FAIL rst_mid got en=%b active=%b fc=%0d data=%h exp all 0",
                     fifo_wr_en, frame_active, frame_count, fifo_wr_data);
        end
        @(negedge clk_periph);
        rstn = 1'b1;
        @(negedge clk_periph);
        settle(); w0 = wr_cnt;
        send_word(32'h7777_0002, 1'b1, 1'b0);
        vectors++;
        if ({err_proto, fifo_wr_en} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_then_pld got proto=%b en=%b exp 1 0", err_proto, fifo_wr_en);
        end
        settle();
        vectors++;
        if (wr_cnt - w0 !== 0) begin
            miscompares++;
            $display("FAIL rst_then_pld_writes got %0d exp 0", wr_cnt - w0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_wc_error();
        test_overflow();
        test_discard();
        test_abort();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mipi_rx_packet_decoder.md
MIPI_RX_PACKET_DECODER -- requirements
Module: mipi_rx_packet_decoder

Interface
REQ-001 SHALL have parameter PIXEL_DT, default 6'h24, meaning the long-packet data type treated as pixel payload (RGB888).
REQ-002 SHALL have port clk_periph  input  1  system clock; all logic rising-edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_hdr_valid  input  1  one-cycle packet-header strobe.
REQ-005 SHALL have port rx_hdr_dt  input  6  header data type.
REQ-006 SHALL have port rx_hdr_wc  input  16  long packet: payload byte count; short packet: data field, ignored.
REQ-007 SHALL have port rx_pld_valid  input  1  payload word strobe.
REQ-008 SHALL have port rx_pld_data  input  32  payload word.
REQ-009 SHALL have port rx_pld_last  input  1  qualifies the final payload word of a packet.
REQ-010 SHALL have port fifo_full  input  1  downstream pixel FIFO full.
REQ-011 SHALL have port fifo_wr_en  output  1  pixel FIFO write strobe.
REQ-012 SHALL have port fifo_wr_data  output  32  pixel FIFO write data.
REQ-013 SHALL have port vsync  output  1  one-cycle frame-start pulse.
REQ-014 SHALL have port hsync  output  1  one-cycle line-start pulse.
REQ-015 SHALL have port frame_active  output  1  high between accepted FS and FE.
REQ-016 SHALL have port line_count  output  16  completed pixel packets in current frame.
REQ-017 SHALL have port frame_count  output  16  completed frames, wraps at 16'hFFFF -> 0.
REQ-018 SHALL have ports err_wc, err_ovf, err_proto  output  1 each  sticky error flags.

Function
REQ-019 SHALL classify headers: dt 0x00 FS, 0x01 FE, 0x02 LS, 0x03 LE, other dt <= 0x0F ignored short, dt >= 0x10 long.
REQ-020 SHALL implement states IDLE (no frame), FRAME (in frame, awaiting header), PAYLOAD (pixel long packet), DISCARD (non-pixel or out-of-frame long packet).
REQ-021 FS in IDLE SHALL: -> FRAME, frame_active=1, line_count=0, clear all error flags, vsync pulse next cycle.
REQ-022 FS in FRAME SHALL act as REQ-021 and additionally set err_proto after the clear.
REQ-023 FE in FRAME SHALL: -> IDLE, frame_active=0, frame_count+1; FE in IDLE SHALL set err_proto only.
REQ-024 LS in FRAME SHALL pulse hsync next cycle; LS in IDLE SHALL set err_proto; LE and ignored shorts SHALL have no effect.
REQ-025 Long header with dt==PIXEL_DT, wc!=0, in FRAME SHALL -> PAYLOAD, expected words = (wc+3)>>2 computed in 17 bits, word counter=0.
REQ-026 Long header with wc!=0 and other dt, or received in IDLE, SHALL -> DISCARD; IDLE case also sets err_proto; DISCARD returns to prior state (FRAME/IDLE) on rx_pld_last.
REQ-027 Long header with wc==0 SHALL cause no state change and no payload expectation.
REQ-028 In PAYLOAD each rx_pld_valid word with counter < expected SHALL produce fifo_wr_en=1, fifo_wr_data=rx_pld_data exactly 1 cycle later, unless fifo_full, in which case word dropped and err_ovf set.
REQ-029 Words beyond expected SHALL be dropped and set err_wc.
REQ-030 On rx_pld_last in PAYLOAD: if words received != expected set err_wc; line_count+1; -> FRAME.
REQ-031 rx_pld_valid in IDLE or FRAME SHALL be ignored and set err_proto.
REQ-032 rx_hdr_valid in PAYLOAD/DISCARD SHALL abort the packet (err_proto, line_count unchanged), then be decoded per REQ-021..027 same cycle; coincident rx_pld_valid dropped.
REQ-033 vsync, hsync, fifo_wr_en SHALL be single-cycle registered pulses; all outputs registered.

Reset
REQ-034 rstn low SHALL asynchronously force state IDLE and every output, counter and flag to 0, including mid-packet; first post-reset action requires an FS.

Verification
REQ-035 Reset, FS, LS, long dt 0x24 wc=12, 3 words, last on 3rd, LE, FE -> vsync 1 pulse, hsync 1 pulse, 3 fifo writes at 1-cycle latency, line_count=1, frame_count=1, no errors.
REQ-036 FS, long dt 0x24 wc=10, 2 words with last -> err_wc=1 (expected 3); wc=8 with 3 words -> 2 writes, err_wc=1.
REQ-037 FS, long dt 0x24 wc=8, fifo_full high on 2nd word -> 1 write, err_ovf=1; next FS clears err_ovf.
REQ-038 Long dt 0x2A wc=8 in FRAME -> no writes, no errors, returns FRAME; long dt 0x24 in IDLE -> no writes, err_proto=1.
REQ-039 Header FE arriving mid-PAYLOAD -> err_proto=1, line_count unchanged, frame_active=0, frame_count+1.
REQ-040 rstn asserted mid-PAYLOAD -> all outputs 0 immediately; subsequent payload without FS -> err_proto=1, no writes.
